// File: rtl/sad_scan_engine.sv
// sad_scan_engine
// Raster-scans every 4x4 candidate position of a FRAME_W x FRAME_W 8-bit frame
// and produces the sum of absolute differences against a latched template.
// Each result goes to the minimum-SAD comparator with a one-cycle strobe.
//
// Ports
//   Clk      clock, all state on the rising edge
//   Rst_n    synchronous active-low reset
//   Start    begin a full scan (sampled only while idle)
//   Tmpl     16-pixel template, pixel k on Tmpl[8k+7:8k], latched at Start
//   MemRe    frame memory read enable
//   MemAddr  frame memory read address, row*FRAME_W + col
//   MemData  read data, valid the cycle after MemRe
//   Sad      SAD of the emitted candidate (registered, held between strobes)
//   X, Y     position of the emitted candidate (registered, held between strobes)
//   en       one-cycle strobe: Sad/X/Y valid
//   Busy     high from Start acceptance until the scan finishes
//   Done     one-cycle pulse after the last candidate
//
// state  | meaning
// IDLE   | waiting for Start
// FETCH  | 16 reads of the current candidate, k = 0..15
// DRAIN  | last read returns; result captured into Sad/X/Y
// EMIT   | en strobe; step to the next position
// FIN    | Done pulse, back to IDLE

module sad_scan_engine #(
    parameter int FRAME_W = 65,
    parameter int MAX_POS = FRAME_W - 4,
    parameter int AW      = 13
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Start,
    input  logic [127:0]  Tmpl,
    output logic          MemRe,
    output logic [AW-1:0] MemAddr,
    input  logic [7:0]    MemData,
    output logic [11:0]   Sad,
    output logic [5:0]    X,
    output logic [5:0]    Y,
    output logic          en,
    output logic          Busy,
    output logic          Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_EMIT,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     k_q, k_d;
    logic [5:0]     pos_x_q, pos_x_d;
    logic [5:0]     pos_y_q, pos_y_d;
    logic [11:0]    acc_q, acc_d;
    logic [127:0]   tmpl_q, tmpl_d;
    logic           rd_vld_q;
    logic [3:0]     rd_k_q;
    logic [11:0]    sad_q, sad_d;
    logic [5:0]     x_q, x_d;
    logic [5:0]     y_q, y_d;

    logic [6:0]        row, col;
    logic [7:0]        tmpl_pix;
    logic signed [8:0] diff;
    logic [7:0]        mag;

    assign MemRe = (state_q == S_FETCH);
    assign en    = (state_q == S_EMIT);
    assign Done  = (state_q == S_FIN);
    assign Busy  = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_EMIT);

    assign row     = {1'b0, pos_y_q} + {5'd0, k_q[3:2]};
    assign col     = {1'b0, pos_x_q} + {5'd0, k_q[1:0]};
    assign MemAddr = MemRe ? (AW'(row) * AW'(FRAME_W) + AW'(col)) : '0;

    // Read data belongs to the pixel requested one cycle earlier.
    assign tmpl_pix = tmpl_q[{rd_k_q, 3'b000} +: 8];
    assign diff     = $signed({1'b0, MemData}) - $signed({1'b0, tmpl_pix});
    assign mag      = diff[8] ? 8'(-diff) : diff[7:0];

    assign Sad = sad_q;
    assign X   = x_q;
    assign Y   = y_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        tmpl_d  = tmpl_q;
        sad_d   = sad_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = rd_vld_q ? (acc_q + 12'(mag)) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    tmpl_d  = Tmpl;
                    pos_x_d = '0;
                    pos_y_d = '0;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // acc_d already includes the 16th pixel arriving this cycle.
                sad_d   = acc_d;
                x_d     = pos_x_q;
                y_d     = pos_y_q;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                acc_d = '0;
                k_d   = '0;
                if (pos_x_q < 6'(MAX_POS)) begin
                    pos_x_d = pos_x_q + 6'd1;
                    state_d = S_FETCH;
                end else if (pos_y_q < 6'(MAX_POS)) begin
                    pos_x_d = '0;
                    pos_y_d = pos_y_q + 6'd1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            acc_q    <= '0;
            tmpl_q   <= '0;
            rd_vld_q <= 1'b0;
            rd_k_q   <= '0;
            sad_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            acc_q    <= acc_d;
            tmpl_q   <= tmpl_d;
            rd_vld_q <= MemRe;
            rd_k_q   <= k_q;
            sad_q    <= sad_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

endmodule
